alen_ctrl: RTL and testbench
============================

# alen_ctrl

Controller that shares the array length store between two requesters: the allocation path, which records an array's length, and the lookup path, which queries the length for an array address. It serialises requests with round-robin arbitration. It sequences the store's write and search modes and re-arms its search engine between queries. It also bounds every search with a timeout, because the store reports hits only.

## Interface
- TIMEOUT, 64, maximum SEARCH cycles before a lookup is declared a miss (≥2)
- clk  in  1  clock
- r  in  1  reset, synchronous, active-high
- alloc_req  in  1  allocation request, level, held until alloc_ack
- alloc_addr  in  32  array address to record
- alloc_len  in  32  array length to record
- alloc_ack  out  1  one-cycle pulse, write issued
- look_req  in  1  lookup request, level, held until look_valid
- look_addr  in  32  array address to query
- look_valid  out  1  one-cycle pulse, result valid
- look_found  out  1  hit flag, valid with look_valid
- look_len  out  32  length on hit, 0 on miss, valid with look_valid
- st_out  out  astore_in_bus_t  {mode, addr, len} to the store
- st_restart  out  1  one-cycle pulse, store search engine returns to its start entry
- st_found  in  1  store hit flag
- st_finished  in  1  store search complete (hit only)
- st_len  in  32  store length output
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WRITE, ARM, SEARCH, DONE.
- IDLE:
  - st_out = {mode 0, addr 0, len 0}.
  - If only one request is high, grant it.
  - If both are high, grant the requester not granted last (register last_grant; reset value = lookup, so alloc wins the first tie).
  - Latch the granted addr, and len for alloc, into internal registers on the grant edge.
- WRITE (1 cycle):
  - st_out = {1, latched addr, latched len}; alloc_ack = 1.
  - Next state IDLE; last_grant = alloc.
- ARM (1 cycle):
  - st_out = {0, latched addr, 0}; st_restart = 1.
  - Timeout counter cleared to 0. Next state SEARCH.
- SEARCH:
  - st_out = {0, latched addr, 0}; counter increments each cycle.
  - If st_finished && st_found: latch st_len into the result register, set found = 1, go to DONE.
  - Else if counter == TIMEOUT-1: set result len = 0, found = 0, go to DONE.
  - A hit in the same cycle as the timeout wins.
  - st_finished without st_found is ignored; search continues.
- DONE (1 cycle):
  - look_valid = 1; look_found and look_len driven from the result registers.
  - Next state IDLE; last_grant = lookup.
- look_found and look_len hold their last values between results.
- Counter width: $clog2(TIMEOUT). No wrap occurs, because the counter is compared before incrementing.
- Requests are not re-sampled while busy. A request dropped before its grant is simply not served. A request still high after its ack or valid is treated as a new request in the next IDLE cycle.

## Timing
- Reset: state IDLE, last_grant = lookup, counter 0, result registers 0. All outputs 0: alloc_ack, look_valid, look_found, look_len, st_out, st_restart, busy.
- Reset in any state aborts the operation. No ack or valid is emitted for it, and the store sees mode 0 from the next cycle.
- Alloc: request sampled in IDLE at edge N. WRITE and alloc_ack occur in cycle N+1. IDLE again at N+2. Back-to-back allocs therefore complete every 2 cycles.
- Lookup: grant at N, ARM at N+1, first SEARCH cycle at N+2.
  - Hit seen in SEARCH cycle N+2+k: look_valid at N+3+k.
  - Miss: look_valid at N+2+TIMEOUT.
- Outputs are registered-state decoded, with no combinational path from alloc_req or look_req to any output.

## Test plan
- Reset with both requests high for 3 cycles -> all outputs 0, busy 0. The first post-reset tie grants alloc.
- Alloc addr 0x10, len 7 -> alloc_ack in cycle 2; st_out = {1, 0x10, 7} for exactly that cycle.
- Lookup 0x10, with the store model hitting 4 cycles into SEARCH and st_len = 7 -> look_valid, look_found 1, look_len 7. st_restart pulses once, in the ARM cycle.
- Lookup 0x99 with the store never finishing, TIMEOUT=8 -> look_valid exactly 10 cycles after the grant; look_found 0, look_len 0.
- Both requests held continuously -> grants alternate alloc, lookup, alloc, lookup. No ack and valid ever occur in the same cycle.
- Assert r in the 3rd SEARCH cycle -> no look_valid; next cycle st_out mode 0 and busy 0. A following lookup completes normally.

Source files
------------

// File: rtl/alen_ctrl_if.sv
// Bundle of the two requester handshakes (allocation, lookup) and the
// array length store port used by alen_ctrl.
// "master" is the side that raises requests and models the store.
// "slave" is the controller.
interface alen_ctrl_if;

  // Command word presented to the array length store.
  // Write mode is mode = 1. Search mode is mode = 0.
  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] len;
  } astore_in_bus_t;

  // allocation path
  logic           alloc_req;
  logic [31:0]    alloc_addr;
  logic [31:0]    alloc_len;
  logic           alloc_ack;

  // lookup path
  logic           look_req;
  logic [31:0]    look_addr;
  logic           look_valid;
  logic           look_found;
  logic [31:0]    look_len;

  // store port
  astore_in_bus_t st_out;
  logic           st_restart;
  logic           st_found;
  logic           st_finished;
  logic [31:0]    st_len;

  modport master (
    output alloc_req, alloc_addr, alloc_len,
    output look_req, look_addr,
    output st_found, st_finished, st_len,
    input  alloc_ack, look_valid, look_found, look_len,
    input  st_out, st_restart
  );

  modport slave (
    input  alloc_req, alloc_addr, alloc_len,
    input  look_req, look_addr,
    input  st_found, st_finished, st_len,
    output alloc_ack, look_valid, look_found, look_len,
    output st_out, st_restart
  );

endinterface

// File: rtl/alen_ctrl.sv
// alen_ctrl: shares the array length store between the allocation path
// (records a length) and the lookup path (queries a length).
// Requests are arbitrated round-robin and served one at a time.
// A lookup re-arms the store's search engine, then searches.
// Because the store only ever reports hits, every search is bounded by
// TIMEOUT cycles.
// Every output is a register. Output values are computed from the next
// state, so the request inputs never reach an output combinationally.
module alen_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     r,
  alen_ctrl_if.slave bus,
  output logic     busy
);

  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    ARM    = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           next_s;

  // 1: the lookup path was served last, so alloc wins the next tie.
  logic             last_lookup_r;

  logic [31:0]      addr_r;
  logic [31:0]      len_r;
  logic [31:0]      addr_next_s;
  logic [31:0]      len_next_s;

  logic [CNT_W-1:0] cnt_r;
  logic             hit_s;
  logic             timeout_s;

  logic             found_r;
  logic [31:0]      res_len_r;

  logic             alloc_ack_r;
  logic             look_valid_r;
  logic             st_restart_r;
  logic             busy_r;
  logic [64:0]      st_out_r;
  logic [64:0]      st_out_next_s;

  // Next-state decode: arbitration in IDLE, search termination in SEARCH.
  always_comb begin
    next_s      = state_r;
    addr_next_s = addr_r;
    len_next_s  = len_r;
    // A finished flag without a hit means nothing; only a real hit ends early.
    hit_s       = bus.st_finished & bus.st_found;
    timeout_s   = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (bus.alloc_req && (!bus.look_req || last_lookup_r)) begin
          next_s      = WRITE;
          addr_next_s = bus.alloc_addr;
          len_next_s  = bus.alloc_len;
        end else if (bus.look_req) begin
          next_s      = ARM;
          addr_next_s = bus.look_addr;
          len_next_s  = 32'd0;
        end else begin
          next_s      = IDLE;
        end
      end
      WRITE: begin
        next_s = IDLE;
      end
      ARM: begin
        next_s = SEARCH;
      end
      SEARCH: begin
        // A hit and the timeout can coincide; both go to DONE, and the
        // result registers give priority to the hit.
        if (hit_s || timeout_s) begin
          next_s = DONE;
        end else begin
          next_s = SEARCH;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Store command for the state about to be entered. It is registered
  // below, so it lines up with that state.
  always_comb begin
    st_out_next_s = 65'd0;
    case (next_s)
      WRITE: begin
        st_out_next_s = {1'b1, addr_next_s, len_next_s};
      end
      ARM, SEARCH: begin
        st_out_next_s = {1'b0, addr_next_s, 32'd0};
      end
      default: begin
        st_out_next_s = 65'd0;
      end
    endcase
  end

  // State register and registered output decode.
  always_ff @(posedge clk) begin
    if (r) begin
      state_r      <= IDLE;
      alloc_ack_r  <= 1'b0;
      look_valid_r <= 1'b0;
      st_restart_r <= 1'b0;
      busy_r       <= 1'b0;
      st_out_r     <= 65'd0;
    end else begin
      state_r      <= next_s;
      alloc_ack_r  <= (next_s == WRITE);
      look_valid_r <= (next_s == DONE);
      st_restart_r <= (next_s == ARM);
      busy_r       <= (next_s != IDLE);
      st_out_r     <= st_out_next_s;
    end
  end

  // Capture the granted request's address/length on the grant edge.
  always_ff @(posedge clk) begin
    if (r) begin
      addr_r <= 32'd0;
      len_r  <= 32'd0;
    end else begin
      addr_r <= addr_next_s;
      len_r  <= len_next_s;
    end
  end

  // Round-robin memory: whoever finished last loses the next tie.
  always_ff @(posedge clk) begin
    if (r) begin
      last_lookup_r <= 1'b1;
    end else if (state_r == WRITE) begin
      last_lookup_r <= 1'b0;
    end else if (state_r == DONE) begin
      last_lookup_r <= 1'b1;
    end else begin
      last_lookup_r <= last_lookup_r;
    end
  end

  // Search timeout counter. It is cleared while arming. It is compared
  // before it increments, so it never wraps.
  always_ff @(posedge clk) begin
    if (r) begin
      cnt_r <= '0;
    end else if (state_r == ARM) begin
      cnt_r <= '0;
    end else if ((state_r == SEARCH) && !hit_s && !timeout_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lookup result registers. They hold their value between results.
  always_ff @(posedge clk) begin
    if (r) begin
      found_r   <= 1'b0;
      res_len_r <= 32'd0;
    end else if ((state_r == SEARCH) && hit_s) begin
      found_r   <= 1'b1;
      res_len_r <= bus.st_len;
    end else if ((state_r == SEARCH) && timeout_s) begin
      found_r   <= 1'b0;
      res_len_r <= 32'd0;
    end else begin
      found_r   <= found_r;
      res_len_r <= res_len_r;
    end
  end

  assign bus.alloc_ack  = alloc_ack_r;
  assign bus.look_valid = look_valid_r;
  assign bus.look_found = found_r;
  assign bus.look_len   = res_len_r;
  assign bus.st_out     = st_out_r;
  assign bus.st_restart = st_restart_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_alen_ctrl.sv
// Directed self-checking bench for alen_ctrl with TIMEOUT = 8.
// The bench drives both requesters and plays the store cycle by cycle.
module tb_alen_ctrl;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic r;
  logic busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_restart = 0;

  alen_ctrl_if bus_if ();

  alen_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .r    (r),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // count st_restart pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (r === 1'b0 && bus_if.st_restart === 1'b1) n_restart <= n_restart + 1;
  end

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store_idle();
    bus_if.st_found    = 1'b0;
    bus_if.st_finished = 1'b0;
    bus_if.st_len      = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found_at;
    int n_ev;
    int both_cnt;
    int ev_kind [4];
    int ev_cyc  [4];

    // ---------------- reset with both requests high
    r                 = 1'b1;
    bus_if.alloc_req  = 1'b1;
    bus_if.look_req   = 1'b1;
    bus_if.alloc_addr = 32'h10;
    bus_if.alloc_len  = 32'd7;
    bus_if.look_addr  = 32'h10;
    store_idle();
    repeat (3) tick();
    check_eq("rst_alloc_ack",  65'(bus_if.alloc_ack),  65'd0);
    check_eq("rst_look_valid", 65'(bus_if.look_valid), 65'd0);
    check_eq("rst_look_found", 65'(bus_if.look_found), 65'd0);
    check_eq("rst_look_len",   65'(bus_if.look_len),   65'd0);
    check_eq("rst_st_out",     65'(bus_if.st_out),     65'd0);
    check_eq("rst_st_restart", 65'(bus_if.st_restart), 65'd0);
    check_eq("rst_busy",       65'(busy),              65'd0);

    // ---------------- first tie goes to alloc: WRITE in cycle after grant
    r = 1'b0;
    tick();
    check_eq("tie_alloc_ack",  65'(bus_if.alloc_ack),  65'd1);
    check_eq("write_st_out",   65'(bus_if.st_out),     {1'b1, 32'h10, 32'd7});
    check_eq("write_busy",     65'(busy),              65'd1);
    check_eq("write_no_valid", 65'(bus_if.look_valid), 65'd0);
    bus_if.alloc_req = 1'b0;
    tick();
    check_eq("idle_ack_low",   65'(bus_if.alloc_ack),  65'd0);
    check_eq("idle_st_out",    65'(bus_if.st_out),     65'd0);
    check_eq("idle_busy",      65'(busy),              65'd0);

    // ---------------- lookup 0x10, hit 4 cycles into SEARCH
    tick();  // ARM
    check_eq("arm_restart",    65'(bus_if.st_restart), 65'd1);
    check_eq("arm_st_out",     65'(bus_if.st_out),     {1'b0, 32'h10, 32'd0});
    tick();  // SEARCH 1
    check_eq("s1_restart_low", 65'(bus_if.st_restart), 65'd0);
    check_eq("s1_st_out",      65'(bus_if.st_out),     {1'b0, 32'h10, 32'd0});
    bus_if.st_finished = 1'b1;  // finished without found: must be ignored
    tick();  // SEARCH 2
    store_idle();
    check_eq("nohit_ignored",  65'(bus_if.look_valid), 65'd0);
    tick();  // SEARCH 3
    tick();  // SEARCH 4
    bus_if.st_finished = 1'b1;
    bus_if.st_found    = 1'b1;
    bus_if.st_len      = 32'd7;
    tick();  // DONE
    check_eq("hit_valid",      65'(bus_if.look_valid), 65'd1);
    check_eq("hit_found",      65'(bus_if.look_found), 65'd1);
    check_eq("hit_len",        65'(bus_if.look_len),   65'd7);
    check_eq("hit_done_st_out",65'(bus_if.st_out),     65'd0);
    store_idle();
    bus_if.look_req = 1'b0;
    tick();
    check_eq("valid_one_cycle",65'(bus_if.look_valid), 65'd0);
    check_eq("found_holds",    65'(bus_if.look_found), 65'd1);
    check_eq("len_holds",      65'(bus_if.look_len),   65'd7);
    check_eq("restart_once",   65'(n_restart),         65'd1);

    // ---------------- lookup 0x99, store never finishes -> miss at grant+10
    bus_if.look_addr = 32'h99;
    bus_if.st_len    = 32'hdead;
    bus_if.look_req  = 1'b1;
    found_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_if.look_valid === 1'b1) begin
        found_at = i;
        break;
      end
    end
    check_eq("miss_latency",   65'(found_at),          65'd10);
    check_eq("miss_found",     65'(bus_if.look_found), 65'd0);
    check_eq("miss_len",       65'(bus_if.look_len),   65'd0);
    bus_if.look_req = 1'b0;
    store_idle();
    tick();

    // ---------------- hit on the last SEARCH cycle beats the timeout
    bus_if.look_addr = 32'h44;
    bus_if.look_req  = 1'b1;
    tick();            // ARM
    repeat (8) tick(); // SEARCH 1..8, now in the last one
    check_eq("last_cycle_busy",65'(busy),              65'd1);
    check_eq("last_cycle_nv",  65'(bus_if.look_valid), 65'd0);
    bus_if.st_finished = 1'b1;
    bus_if.st_found    = 1'b1;
    bus_if.st_len      = 32'h55;
    tick();
    check_eq("edge_hit_valid", 65'(bus_if.look_valid), 65'd1);
    check_eq("edge_hit_found", 65'(bus_if.look_found), 65'd1);
    check_eq("edge_hit_len",   65'(bus_if.look_len),   65'd85);
    store_idle();
    bus_if.look_req = 1'b0;
    tick();

    // ---------------- both held: alloc, lookup, alloc, lookup
    bus_if.alloc_addr = 32'h20;
    bus_if.alloc_len  = 32'd3;
    bus_if.look_addr  = 32'h20;
    bus_if.alloc_req  = 1'b1;
    bus_if.look_req   = 1'b1;
    n_ev = 0;
    both_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ev_kind[i] = -1;
      ev_cyc[i]  = -1;
    end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_if.alloc_ack === 1'b1 && bus_if.look_valid === 1'b1) both_cnt++;
      if (bus_if.alloc_ack === 1'b1 || bus_if.look_valid === 1'b1) begin
        ev_kind[n_ev] = (bus_if.alloc_ack === 1'b1) ? 0 : 1;
        ev_cyc[n_ev]  = i;
        n_ev++;
        if (n_ev == 4) begin
          bus_if.alloc_req = 1'b0;
          bus_if.look_req  = 1'b0;
          break;
        end
      end
    end
    check_eq("alt_events",     65'(n_ev),       65'd4);
    check_eq("alt_no_overlap", 65'(both_cnt),   65'd0);
    check_eq("alt_kind0",      65'(ev_kind[0]), 65'd0);
    check_eq("alt_kind1",      65'(ev_kind[1]), 65'd1);
    check_eq("alt_kind2",      65'(ev_kind[2]), 65'd0);
    check_eq("alt_kind3",      65'(ev_kind[3]), 65'd1);
    check_eq("alt_cyc0",       65'(ev_cyc[0]),  65'd1);
    check_eq("alt_cyc1",       65'(ev_cyc[1]),  65'd12);
    check_eq("alt_cyc2",       65'(ev_cyc[2]),  65'd14);
    check_eq("alt_cyc3",       65'(ev_cyc[3]),  65'd25);
    tick();
    tick();
    check_eq("alt_idle_busy",  65'(busy),       65'd0);

    // ---------------- reset in the 3rd SEARCH cycle aborts the lookup
    bus_if.look_addr = 32'h33;
    bus_if.look_req  = 1'b1;
    tick();  // ARM
    tick();  // SEARCH 1
    tick();  // SEARCH 2
    tick();  // SEARCH 3
    r = 1'b1;
    bus_if.look_req = 1'b0;
    tick();
    check_eq("abort_no_valid", 65'(bus_if.look_valid), 65'd0);
    check_eq("abort_st_out",   65'(bus_if.st_out),     65'd0);
    check_eq("abort_busy",     65'(busy),              65'd0);
    r = 1'b0;
    tick();
    tick();
    check_eq("abort_late_nv",  65'(bus_if.look_valid), 65'd0);

    // ---------------- following lookup completes, hit on first SEARCH cycle
    bus_if.look_addr = 32'h10;
    bus_if.look_req  = 1'b1;
    tick();  // ARM
    check_eq("post_arm_rst",   65'(bus_if.st_restart), 65'd1);
    tick();  // SEARCH 1
    bus_if.st_finished = 1'b1;
    bus_if.st_found    = 1'b1;
    bus_if.st_len      = 32'd7;
    tick();
    check_eq("post_valid",     65'(bus_if.look_valid), 65'd1);
    check_eq("post_found",     65'(bus_if.look_found), 65'd1);
    check_eq("post_len",       65'(bus_if.look_len),   65'd7);
    store_idle();
    bus_if.look_req = 1'b0;
    tick();
    check_eq("post_idle_busy", 65'(busy),              65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
